// File: rtl/hash_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hash_mem_pkg
// Description : Shared widths and the window-tracker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hash_mem_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        COLLECT = 2'd2,
        READY   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hash_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : hash_mem_array
// Description : Single-write word RAM with two registered read ports and
//               out-of-range flags for each read address.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_mem_array
    import hash_mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [WORD_W-1:0] a_rdata,
    output logic              a_oor,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [WORD_W-1:0] b_rdata,
    output logic              b_oor
);

    localparam int               c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_a_rdata;
    logic [WORD_W-1:0] r_b_rdata;
    logic              w_w_oor;

    assign w_w_oor = {1'b0, waddr}  >= c_DEPTH;
    assign a_oor   = {1'b0, a_addr} >= c_DEPTH;
    assign b_oor   = {1'b0, b_addr} >= c_DEPTH;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we && !w_w_oor) begin
            r_mem[waddr[c_IDX_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_a_rdata <= a_oor ? '0 : r_mem[a_addr[c_IDX_W-1:0]];
            if (b_en) begin
                r_b_rdata <= b_oor ? '0 : r_mem[b_addr[c_IDX_W-1:0]];
            end
        end
    end

    assign a_rdata = r_a_rdata;
    assign b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/hash_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : hash_mem_responder
// Description : Memory responder for the hash cores with host access and a
//               result-window completion tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_mem_responder
    import hash_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int NUM_RESULTS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_write_data,
    output logic [WORD_W-1:0] mem_read_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WORD_W-1:0] host_wdata,
    output logic              host_grant,
    output logic [WORD_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              arm,
    input  logic [ADDR_W-1:0] out_base,
    output logic              results_ready,
    output logic [7:0]        write_count,
    output logic              addr_err
);

    localparam int              c_IDX_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
    localparam logic [7:0]      c_NUM   = 8'(NUM_RESULTS);
    localparam logic [ADDR_W:0] c_SPAN  = (ADDR_W + 1)'(NUM_RESULTS);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDR_W-1:0]        r_base;
    logic [NUM_RESULTS-1:0]   r_bitmap;
    logic [7:0]               r_write_count;
    logic                     r_addr_err;
    logic                     r_host_rvalid;

    logic                     w_host_ok;
    logic                     w_host_wr;
    logic                     w_we;
    logic [ADDR_W-1:0]        w_waddr;
    logic [WORD_W-1:0]        w_wdata;
    logic                     w_core_oor;
    logic                     w_host_oor;
    logic [ADDR_W-1:0]        w_offset;
    logic                     w_win_wr;
    logic                     w_new_hit;
    logic                     w_done;
    logic                     w_arm_ok;

    assign w_host_ok  = (r_state == IDLE) || (r_state == READY);
    assign host_grant = host_req && w_host_ok;
    assign w_host_wr  = host_grant && host_we;

    // Core has priority on the single write port.
    assign w_we    = mem_we || w_host_wr;
    assign w_waddr = mem_we ? mem_addr       : host_addr;
    assign w_wdata = mem_we ? mem_write_data : host_wdata;

    hash_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .a_addr  (mem_addr),
        .a_rdata (mem_read_data),
        .a_oor   (w_core_oor),
        .b_en    (host_grant && !host_we),
        .b_addr  (host_addr),
        .b_rdata (host_rdata),
        .b_oor   (w_host_oor)
    );

    // 17-bit upper bound so the window never wraps past 0xFFFF.
    assign w_offset  = mem_addr - r_base;
    assign w_win_wr  = mem_we && !w_core_oor && (mem_addr >= r_base) &&
                       ({1'b0, mem_addr} < ({1'b0, r_base} + c_SPAN));
    assign w_new_hit = w_win_wr && ((r_state == ARMED) || (r_state == COLLECT)) &&
                       !r_bitmap[w_offset[c_IDX_W-1:0]];
    assign w_done    = w_new_hit && ((r_write_count + 8'd1) == c_NUM);
    assign w_arm_ok  = arm && w_host_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (arm) w_next_state = ARMED;
            ARMED:   if (w_new_hit) w_next_state = w_done ? READY : COLLECT;
            COLLECT: if (w_done) w_next_state = READY;
            READY:   if (arm) w_next_state = ARMED;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base        <= '0;
            r_bitmap      <= '0;
            r_write_count <= '0;
        end else if (w_arm_ok) begin
            r_base        <= out_base;
            r_bitmap      <= '0;
            r_write_count <= '0;
        end else if (w_new_hit) begin
            r_bitmap[w_offset[c_IDX_W-1:0]] <= 1'b1;
            r_write_count                   <= r_write_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err    <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_host_rvalid <= host_grant && !host_we;
            if (w_core_oor || (host_grant && w_host_oor)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign results_ready = (r_state == READY);
    assign write_count   = r_write_count;
    assign addr_err      = r_addr_err;
    assign host_rvalid   = r_host_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_hash_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_mem_responder
// Description : Directed self-checking bench for hash_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_grant;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        arm;
    logic [15:0] out_base;
    logic        results_ready;
    logic [7:0]  write_count;
    logic        addr_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hash_mem_responder #(
        .DEPTH       (1024),
        .NUM_RESULTS (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_grant     (host_grant),
        .host_rdata     (host_rdata),
        .host_rvalid    (host_rvalid),
        .arm            (arm),
        .out_base       (out_base),
        .results_ready  (results_ready),
        .write_count    (write_count),
        .addr_err       (addr_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        arm = 1'b0; out_base = '0;
        step(); step();
        check("rst_rdata",   mem_read_data, 32'h0);
        check("rst_hrdata",  host_rdata, 32'h0);
        check("rst_hrvalid", {31'b0, host_rvalid}, 32'h0);
        check("rst_ready",   {31'b0, results_ready}, 32'h0);
        check("rst_count",   {24'b0, write_count}, 32'h0);
        check("rst_err",     {31'b0, addr_err}, 32'h0);
        reset = 1'b0;

        // Host preload in IDLE
        host_req = 1'b1; host_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_addr  = 16'(i);
            host_wdata = 32'h11111111 + 32'(i);
            #1;
            check("pre_grant", {31'b0, host_grant}, 32'h1);
            step();
        end
        host_addr = 16'd5; host_wdata = 32'h55;
        step();

        host_we = 1'b0; host_addr = 16'd1;
        #1;
        check("hrd_grant", {31'b0, host_grant}, 32'h1);
        step();
        host_req = 1'b0;
        check("hrd_rvalid", {31'b0, host_rvalid}, 32'h1);
        check("hrd_data",   host_rdata, 32'h11111112);
        step();
        check("hrd_rvalid_drop", {31'b0, host_rvalid}, 32'h0);

        // Core read latency and read-before-write
        mem_addr = 16'd2;
        step();
        check("core_rd2", mem_read_data, 32'h11111113);
        mem_addr = 16'd5; mem_we = 1'b1; mem_write_data = 32'hAA;
        step();
        mem_we = 1'b0;
        check("rbw_old", mem_read_data, 32'h55);
        step();
        check("rbw_new", mem_read_data, 32'hAA);

        // Full collection of 16 window words
        arm = 1'b1; out_base = 16'h0100;
        step();
        arm = 1'b0;
        check("arm_count", {24'b0, write_count}, 32'h0);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'd0;
        for (int i = 0; i < 16; i++) begin
            mem_we = 1'b1; mem_addr = 16'h0100 + 16'(i); mem_write_data = 32'(i);
            #1;
            check("col_nogrant", {31'b0, host_grant}, 32'h0);
            step();
            check("col_count", {24'b0, write_count}, 32'(i + 1));
            check("col_ready", {31'b0, results_ready}, (i == 15) ? 32'h1 : 32'h0);
        end
        mem_we = 1'b0; mem_addr = 16'd0;
        #1;
        check("ready_grant", {31'b0, host_grant}, 32'h1);
        host_req = 1'b0;

        // Re-arm from READY; duplicates and outside writes
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm_ready", {31'b0, results_ready}, 32'h0);
        check("rearm_count", {24'b0, write_count}, 32'h0);
        mem_we = 1'b1; mem_write_data = 32'hC0DE0000;
        mem_addr = 16'h0100; step(); step(); step();
        mem_addr = 16'h0200; step();
        mem_we = 1'b0; mem_addr = 16'd0;
        host_req = 1'b1;
        #1;
        check("dup_count", {24'b0, write_count}, 32'h1);
        check("dup_ready", {31'b0, results_ready}, 32'h0);
        check("dup_nogrant", {31'b0, host_grant}, 32'h0);
        host_req = 1'b0;

        // Out-of-range core write
        mem_we = 1'b1; mem_addr = 16'h0400; mem_write_data = 32'hDEAD;
        step();
        mem_we = 1'b0;
        check("oor_rdata", mem_read_data, 32'h0);
        check("oor_err",   {31'b0, addr_err}, 32'h1);
        mem_addr = 16'd0;
        step();
        check("oor_alias", mem_read_data, 32'h11111111);
        check("oor_sticky", {31'b0, addr_err}, 32'h1);

        // Six more window words bring the count to 7, then reset
        mem_we = 1'b1;
        for (int j = 0; j < 6; j++) begin
            mem_addr = 16'h0101 + 16'(j); mem_write_data = 32'hB0000000 + 32'(j);
            step();
        end
        mem_we = 1'b0; mem_addr = 16'd0;
        check("pre_rst_count", {24'b0, write_count}, 32'h7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_count", {24'b0, write_count}, 32'h0);
        check("mid_rst_ready", {31'b0, results_ready}, 32'h0);
        check("mid_rst_err",   {31'b0, addr_err}, 32'h0);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0103;
        #1;
        check("mid_rst_grant", {31'b0, host_grant}, 32'h1);
        step();
        check("keep_data",   host_rdata, 32'hB0000002);
        check("keep_rvalid", {31'b0, host_rvalid}, 32'h1);

        // Out-of-range host read
        host_addr = 16'h0400;
        step();
        host_req = 1'b0;
        check("hoor_rdata",  host_rdata, 32'h0);
        check("hoor_rvalid", {31'b0, host_rvalid}, 32'h1);
        check("hoor_err",    {31'b0, addr_err}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
